// File: rtl/uart_tx_module.sv
// UART transmitter: start, 8 data bits LSB first, optional parity, 1-2 stop bits; bit = div+1 cycles.
// Start bit begins the cycle after the FIFO pop; back-to-back frames have no idle gap when the FIFO has data.
module uart_tx_module #(
   parameter int DIV_W = 16
) (
   input  logic             glb_clk,
   input  logic             glb_rst,
   input  logic             Cfg_ctrl_stopbit,
   input  logic [1:0]       Cfg_ctrl_paritybit,
   input  logic             Cfg_ctrl_Tx_en,
   input  logic [DIV_W-1:0] Cfg_ctrl_baud_div,
   input  logic             FIFO_ctrl_empty,
   input  logic [7:0]       FIFO_data_payload,
   output logic             UART_ctrl_FIFO_r_en,
   output logic             usr_data_txbit,
   output logic             UART_Tx_busy
);

   typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP1, STOP2} state_t;

   state_t           state_q, state_nxt;
   logic [DIV_W-1:0] cnt_q, cnt_nxt;
   logic [DIV_W-1:0] div_q, div_nxt;
   logic [7:0]       shreg_q, shreg_nxt;
   logic [2:0]       bit_idx_q, bit_idx_nxt;
   logic             stop2_q, stop2_nxt;
   logic             par_en_q, par_en_nxt;
   logic             par_val_q, par_val_nxt;
   logic             line_q, line_nxt;
   logic             r_en_c;
   logic             frame_end;
   logic             bit_end;

   assign bit_end = (cnt_q == '0);

   always_comb begin
      state_nxt   = state_q;
      cnt_nxt     = bit_end ? cnt_q : cnt_q - DIV_W'(1);
      div_nxt     = div_q;
      shreg_nxt   = shreg_q;
      bit_idx_nxt = bit_idx_q;
      stop2_nxt   = stop2_q;
      par_en_nxt  = par_en_q;
      par_val_nxt = par_val_q;
      line_nxt    = line_q;
      r_en_c      = 1'b0;
      frame_end   = 1'b0;

      case (state_q)
         IDLE: frame_end = 1'b1;
         START: begin
            if (bit_end) begin
               state_nxt   = DATA;
               cnt_nxt     = div_q;
               bit_idx_nxt = 3'd0;
               line_nxt    = shreg_q[0];
            end
         end
         DATA: begin
            if (bit_end) begin
               shreg_nxt = shreg_q >> 1;
               cnt_nxt   = div_q;
               if (bit_idx_q == 3'd7) begin
                  if (par_en_q) begin
                     state_nxt = PARITY;
                     line_nxt  = par_val_q;
                  end else begin
                     state_nxt = STOP1;
                     line_nxt  = 1'b1;
                  end
               end else begin
                  bit_idx_nxt = bit_idx_q + 3'd1;
                  line_nxt    = shreg_q[1];
               end
            end
         end
         PARITY: begin
            if (bit_end) begin
               state_nxt = STOP1;
               cnt_nxt   = div_q;
               line_nxt  = 1'b1;
            end
         end
         STOP1: begin
            if (bit_end) begin
               if (stop2_q) begin
                  state_nxt = STOP2;
                  cnt_nxt   = div_q;
                  line_nxt  = 1'b1;
               end else begin
                  frame_end = 1'b1;
               end
            end
         end
         STOP2: if (bit_end) frame_end = 1'b1;
         default: state_nxt = IDLE;
      endcase

      // Fetch path shared by IDLE and the last stop-bit cycle; format is latched here.
      if (frame_end) begin
         if (Cfg_ctrl_Tx_en && !FIFO_ctrl_empty) begin
            r_en_c      = 1'b1;
            state_nxt   = START;
            cnt_nxt     = Cfg_ctrl_baud_div;
            div_nxt     = Cfg_ctrl_baud_div;
            shreg_nxt   = FIFO_data_payload;
            stop2_nxt   = Cfg_ctrl_stopbit;
            par_en_nxt  = (Cfg_ctrl_paritybit == 2'b01) || (Cfg_ctrl_paritybit == 2'b10);
            par_val_nxt = (Cfg_ctrl_paritybit == 2'b10) ? ^FIFO_data_payload : ~^FIFO_data_payload;
            line_nxt    = 1'b0;
         end else begin
            state_nxt = IDLE;
            cnt_nxt   = '0;
            line_nxt  = 1'b1;
         end
      end
   end

   always_ff @(posedge glb_clk or posedge glb_rst) begin
      if (glb_rst) begin
         state_q   <= IDLE;
         cnt_q     <= '0;
         div_q     <= '0;
         shreg_q   <= '0;
         bit_idx_q <= '0;
         stop2_q   <= 1'b0;
         par_en_q  <= 1'b0;
         par_val_q <= 1'b0;
         line_q    <= 1'b1;
      end else begin
         state_q   <= state_nxt;
         cnt_q     <= cnt_nxt;
         div_q     <= div_nxt;
         shreg_q   <= shreg_nxt;
         bit_idx_q <= bit_idx_nxt;
         stop2_q   <= stop2_nxt;
         par_en_q  <= par_en_nxt;
         par_val_q <= par_val_nxt;
         line_q    <= line_nxt;
      end
   end

   // The pop strobe is combinational, so mask it while reset holds the FSM in IDLE.
   assign UART_ctrl_FIFO_r_en = r_en_c & ~glb_rst;
   assign usr_data_txbit      = line_q;
   assign UART_Tx_busy        = (state_q != IDLE);

endmodule

// File: tb/tb_uart_tx_module.sv
// Bench for uart_tx_module: FIFO model, expected-frame scoreboard and a per-cycle line monitor.
module tb_uart_tx_module;

   logic        glb_clk = 1'b0;
   logic        glb_rst;
   logic        Cfg_ctrl_stopbit;
   logic [1:0]  Cfg_ctrl_paritybit;
   logic        Cfg_ctrl_Tx_en;
   logic [15:0] Cfg_ctrl_baud_div;
   logic        FIFO_ctrl_empty;
   logic [7:0]  FIFO_data_payload;
   logic        UART_ctrl_FIFO_r_en;
   logic        usr_data_txbit;
   logic        UART_Tx_busy;

   uart_tx_module #(.DIV_W(16)) dut (
      .glb_clk             (glb_clk),
      .glb_rst             (glb_rst),
      .Cfg_ctrl_stopbit    (Cfg_ctrl_stopbit),
      .Cfg_ctrl_paritybit  (Cfg_ctrl_paritybit),
      .Cfg_ctrl_Tx_en      (Cfg_ctrl_Tx_en),
      .Cfg_ctrl_baud_div   (Cfg_ctrl_baud_div),
      .FIFO_ctrl_empty     (FIFO_ctrl_empty),
      .FIFO_data_payload   (FIFO_data_payload),
      .UART_ctrl_FIFO_r_en (UART_ctrl_FIFO_r_en),
      .usr_data_txbit      (usr_data_txbit),
      .UART_Tx_busy        (UART_Tx_busy)
   );

   always #5 glb_clk = ~glb_clk;

   // FIFO model: the stimulus owns wr_ptr, the pop process owns rd_ptr.
   logic [7:0] mem [0:31];
   int wr_ptr = 0;
   int rd_ptr = 0;
   int ren_cnt = 0;
   int ren_bad = 0;
   assign FIFO_ctrl_empty   = (wr_ptr == rd_ptr);
   assign FIFO_data_payload = mem[rd_ptr % 32];

   always @(posedge glb_clk) begin
      if (UART_ctrl_FIFO_r_en) begin
         if (FIFO_ctrl_empty) ren_bad <= ren_bad + 1;
         else rd_ptr <= rd_ptr + 1;
         ren_cnt <= ren_cnt + 1;
      end
   end

   typedef struct {
      logic [7:0] data;
      logic [1:0] par;
      logic       stop2;
      int         div;
      bit         b2b;
   } frm_t;

   frm_t exp_q [$];

   int  tests = 0;
   int  fails = 0;
   int  idle_err = 0;
   int  to_cnt = 0;
   int  exp_ren = 0;
   bit  chk_req = 0;
   bit  chk_ack = 0;
   bit  in_frame = 0;

   // Monitor / scoreboard
   frm_t        cur;
   logic [11:0] ev;
   int          flen, cyc, ferr, f_cyc;
   logic        f_line, f_busy;
   bit          rst_seen = 0;
   bit          b2b_pend = 0;

   always @(negedge glb_clk) begin
      if (glb_rst) begin
         if (!rst_seen) begin
            rst_seen = 1;
            tests++;
            if (usr_data_txbit !== 1'b1 || UART_Tx_busy !== 1'b0 || UART_ctrl_FIFO_r_en !== 1'b0) begin
               fails++;
               $display("FAIL reset_state: line=%b busy=%b r_en=%b, required 1 0 0",
                        usr_data_txbit, UART_Tx_busy, UART_ctrl_FIFO_r_en);
            end
         end
         in_frame = 0;
         b2b_pend = 0;
      end else begin
         rst_seen = 0;
         if (b2b_pend) begin
            b2b_pend = 0;
            tests++;
            if (usr_data_txbit !== 1'b0) begin
               fails++;
               $display("FAIL b2b_gap: line=%b after stop, required 0", usr_data_txbit);
            end
         end
         if (!in_frame) begin
            if (usr_data_txbit === 1'b0) begin
               if (exp_q.size() == 0) begin
                  tests++;
                  fails++;
                  $display("FAIL unexpected_frame: start bit seen, 0 frames expected");
               end else begin
                  cur = exp_q.pop_front();
                  ev = 12'hFFF;
                  ev[0] = 1'b0;
                  ev[8:1] = cur.data;
                  flen = 10;
                  if (cur.par == 2'b01) begin ev[9] = ~^cur.data; flen++; end
                  if (cur.par == 2'b10) begin ev[9] = ^cur.data;  flen++; end
                  if (cur.stop2) flen++;
                  flen = flen * (cur.div + 1);
                  in_frame = 1;
                  cyc = 0;
                  ferr = 0;
               end
            end else if (UART_Tx_busy !== 1'b0) begin
               idle_err++;
            end
         end
         if (in_frame) begin
            if (usr_data_txbit !== ev[cyc / (cur.div + 1)] || UART_Tx_busy !== 1'b1) begin
               if (ferr == 0) begin
                  f_cyc = cyc;
                  f_line = usr_data_txbit;
                  f_busy = UART_Tx_busy;
               end
               ferr++;
            end
            cyc++;
            if (cyc == flen) begin
               tests++;
               if (ferr != 0) begin
                  fails++;
                  $display("FAIL frame_%02h: cycle %0d line=%b busy=%b, required line=%b busy=1 (%0d bad cycles)",
                           cur.data, f_cyc, f_line, f_busy, ev[f_cyc / (cur.div + 1)], ferr);
               end
               in_frame = 0;
               b2b_pend = cur.b2b;
            end
         end
         if (chk_req != chk_ack) begin
            tests++;
            if (ren_cnt != exp_ren || ren_bad != 0 || idle_err != 0 || to_cnt != 0 || exp_q.size() != 0) begin
               fails++;
               $display("FAIL checkpoint: r_en=%0d bad=%0d idle_err=%0d timeouts=%0d pending=%0d, required r_en=%0d and zeros",
                        ren_cnt, ren_bad, idle_err, to_cnt, exp_q.size(), exp_ren);
            end
            chk_ack = chk_req;
         end
      end
   end

   task automatic put(input logic [7:0] d);
      mem[wr_ptr % 32] = d;
      wr_ptr++;
   endtask

   task automatic expect_frame(input logic [7:0] d, input bit b2b);
      frm_t f;
      f.data  = d;
      f.par   = Cfg_ctrl_paritybit;
      f.stop2 = Cfg_ctrl_stopbit;
      f.div   = int'(Cfg_ctrl_baud_div);
      f.b2b   = b2b;
      exp_q.push_back(f);
   endtask

   task automatic send(input logic [7:0] d);
      expect_frame(d, 0);
      put(d);
      wait_quiet();
   endtask

   task automatic wait_start();
      int n = 0;
      while (usr_data_txbit !== 1'b0 && n < 200) begin
         @(negedge glb_clk);
         n++;
      end
      if (n >= 200) to_cnt++;
   endtask

   task automatic wait_quiet();
      int n = 0;
      int q = 0;
      @(negedge glb_clk);
      while (q < 3 && n < 3000) begin
         if (!UART_Tx_busy && usr_data_txbit && !in_frame && (FIFO_ctrl_empty || !Cfg_ctrl_Tx_en)) q++;
         else q = 0;
         @(negedge glb_clk);
         n++;
      end
      if (n >= 3000) to_cnt++;
   endtask

   task automatic check(input int n);
      int t = 0;
      exp_ren = n;
      chk_req = ~chk_req;
      while (chk_ack != chk_req && t < 20) begin
         @(negedge glb_clk);
         t++;
      end
      if (chk_ack != chk_req) begin
         $display("FAIL checkpoint_handshake: no response after %0d cycles", t);
         $fatal(1, "checkpoint stalled");
      end
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      glb_rst            = 1'b1;
      Cfg_ctrl_Tx_en     = 1'b0;
      Cfg_ctrl_baud_div  = 16'd3;
      Cfg_ctrl_paritybit = 2'b00;
      Cfg_ctrl_stopbit   = 1'b0;
      repeat (3) @(negedge glb_clk);
      glb_rst = 1'b0;

      // 0x55, div=3, no parity, 1 stop; config disturbed mid-frame must not matter
      expect_frame(8'h55, 0);
      put(8'h55);
      Cfg_ctrl_Tx_en = 1'b1;
      wait_start();
      repeat (2) @(negedge glb_clk);
      Cfg_ctrl_baud_div  = 16'd9;
      Cfg_ctrl_paritybit = 2'b10;
      Cfg_ctrl_stopbit   = 1'b1;
      wait_quiet();
      check(1);

      // parity modes, div=1
      Cfg_ctrl_baud_div = 16'd1;
      Cfg_ctrl_stopbit  = 1'b0;
      Cfg_ctrl_paritybit = 2'b10; send(8'hA5);
      Cfg_ctrl_paritybit = 2'b01; send(8'hA5);
      Cfg_ctrl_paritybit = 2'b10; send(8'h01);
      Cfg_ctrl_paritybit = 2'b11; send(8'h01);
      check(5);

      // div=0 with two and one stop bits
      Cfg_ctrl_baud_div  = 16'd0;
      Cfg_ctrl_paritybit = 2'b00;
      Cfg_ctrl_stopbit   = 1'b1; send(8'hFF);
      Cfg_ctrl_stopbit   = 1'b0; send(8'hFF);
      check(7);

      // back-to-back frames, div=2
      Cfg_ctrl_Tx_en    = 1'b0;
      Cfg_ctrl_baud_div = 16'd2;
      put(8'h12);
      put(8'h34);
      expect_frame(8'h12, 1);
      expect_frame(8'h34, 0);
      Cfg_ctrl_Tx_en = 1'b1;
      wait_quiet();
      check(9);

      // disabled with data present, then enabled, then enabled with empty FIFO
      Cfg_ctrl_Tx_en = 1'b0;
      put(8'h77);
      repeat (60) @(negedge glb_clk);
      check(9);
      expect_frame(8'h77, 0);
      Cfg_ctrl_Tx_en = 1'b1;
      wait_quiet();
      check(10);
      repeat (40) @(negedge glb_clk);
      check(10);

      // Tx_en dropped during DATA: frame completes, next byte stays queued
      Cfg_ctrl_Tx_en    = 1'b0;
      Cfg_ctrl_baud_div = 16'd1;
      put(8'h3C);
      put(8'hC3);
      expect_frame(8'h3C, 0);
      Cfg_ctrl_Tx_en = 1'b1;
      wait_start();
      repeat (6) @(negedge glb_clk);
      Cfg_ctrl_Tx_en = 1'b0;
      wait_quiet();
      repeat (20) @(negedge glb_clk);
      check(11);

      // async reset inside data bit 3 of 0xC3, then 0x5A must go out cleanly
      put(8'h5A);
      expect_frame(8'hC3, 0);
      expect_frame(8'h5A, 0);
      Cfg_ctrl_Tx_en = 1'b1;
      wait_start();
      repeat (8) @(negedge glb_clk);
      @(posedge glb_clk);
      #1 glb_rst = 1'b1;
      repeat (2) @(negedge glb_clk);
      glb_rst = 1'b0;
      wait_quiet();
      check(13);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule

// File: doc/uart_tx_module.md
Name: uart_tx_module

Overview:
UART transmit engine; the transmit-side counterpart of the UART receive path in UART_core. It pops bytes from the Tx FIFO, serialises each as start bit, 8 data bits LSB first, optional parity, and 1 or 2 stop bits. Its bit timing comes from an internal baud divider, with one baud period per bit and no oversampling. Frame format is taken from the same Cfg_ctrl_* configuration fields the receiver uses.

Parameters:
DIV_W, 16, width of the baud divider configuration and counter.

Ports:
glb_clk  input  1  system clock
glb_rst  input  1  asynchronous active-high reset
Cfg_ctrl_stopbit  input  1  0 = one stop bit, 1 = two stop bits
Cfg_ctrl_paritybit  input  2  00 = none, 01 = odd, 10 = even, 11 = none (reserved)
Cfg_ctrl_Tx_en  input  1  transmit enable; gates fetching of new frames only
Cfg_ctrl_baud_div  input  DIV_W  bit period = Cfg_ctrl_baud_div+1 glb_clk cycles
FIFO_ctrl_empty  input  1  Tx FIFO empty flag
FIFO_data_payload  input  8  FIFO head word (first-word-fall-through), valid while not empty
UART_ctrl_FIFO_r_en  output  1  one-cycle pop strobe
usr_data_txbit  output  1  serial line, idle high
UART_Tx_busy  output  1  high while a frame is in progress

Behaviour:
- Reset (asynchronous, active-high): state IDLE, usr_data_txbit=1, UART_ctrl_FIFO_r_en=0, UART_Tx_busy=0, baud counter=0, shift register=0. Reset mid-frame drives the line high immediately and drops the frame. The FIFO is not re-popped.
- States: IDLE, START, DATA, PARITY, STOP1, STOP2.
- Frame fetch in IDLE: when Cfg_ctrl_Tx_en=1 and FIFO_ctrl_empty=0, assert r_en for exactly one cycle. In that same cycle, capture FIFO_data_payload, stopbit, paritybit and baud_div into internal registers. Next state is START.
  - Configuration changes mid-frame have no effect until the next fetch.
- Baud counter: loads the latched div at entry to each bit and decrements every cycle. A bit ends on the cycle the counter is 0, so each bit lasts exactly div+1 cycles. div=0 gives 1 cycle per bit.
- Line output is registered; it changes on the first cycle of each bit:
  - START: 0.
  - DATA: shift register LSB. Shift right at each bit end. Bit index counts 0..7, then the next state is PARITY if parity is enabled, else STOP1.
  - PARITY: even mode sends XOR of the 8 data bits; odd mode sends its inverse.
  - STOP1 and STOP2: 1.
- Exit from STOP1: go to STOP2 if the latched stopbit=1, else end the frame.
- Line timing: the START bit begins the cycle after r_en. Frame length = (1+8+P+S)*(div+1) cycles, where P is 0 or 1 and S is 1 or 2.
- End of frame: on the final cycle of the last stop bit, if Tx_en=1 and FIFO not empty, assert r_en that cycle and go directly to START. This gives back-to-back frames with zero idle cycles. Otherwise go to IDLE.
- Tx_en deasserted mid-frame: the current frame completes unchanged. No further fetch occurs.
- r_en is never asserted while FIFO_ctrl_empty=1, and never more than once per frame.
- UART_Tx_busy: 1 from the cycle after r_en through the last stop-bit cycle. It is 0 in IDLE, including the fetch cycle itself.
- Parity code 11 behaves exactly as 00.

Test Plan:
- div=3, no parity, 1 stop bit, FIFO holds 0x55 → one r_en pulse. Line is then 0 for 4 cycles, followed by data 1,0,1,0,1,0,1,0 at 4 cycles each, then 1 for 4 cycles. Busy is high for 40 cycles, then the line idles high.
- div=1, parity bits: 0xA5 with even parity gives parity bit 0 and a 22-cycle frame. 0xA5 with odd parity gives 1. 0x01 with even parity gives 1.
- div=0, two stop bits, parity none, data 0xFF → 11-cycle frame with the last two bits high. Check that STOP2 is skipped when stopbit=0 (10-cycle frame).
- FIFO holds 0x12 and 0x34, div=2 → the second r_en fires on the last cycle of the first stop bit. Line goes directly from stop to start with no idle cycle. There are exactly two r_en pulses in total.
- FIFO empty, or Tx_en=0 with data present → no r_en, line constant 1, busy 0. Drop Tx_en during DATA → the frame completes and the next byte is not popped.
- Assert glb_rst during the DATA bit 3 window → line is 1 and busy is 0 within the same cycle (asynchronous). After release with FIFO non-empty, the next frame starts cleanly with a full-length start bit.
